// File: rtl/spi_master.sv
// SPI master, mode 0 (SCK idles low), MSB first, one byte per frame.
// SCK half-period is CLK_DIV clk_i cycles; every output is driven straight from a flop.
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       SCK,
  output logic       MOSI,
  output logic       SS,
  input  logic       MISO
);

  localparam int unsigned CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] HalfLast = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StGap} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   half_q, half_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      tx_sr_q, tx_sr_d;
  logic [7:0]      rx_sr_q, rx_sr_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            miso_s1_q, miso_s2_q;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic            ss_q, ss_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tick;

  assign tick = (half_q == HalfLast);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      half_q    <= '0;
      bit_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      miso_s1_q <= MISO;
      miso_s2_q <= miso_s1_q;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // The bit counter advances on every falling SCK edge and wraps 7 -> 0, so a low-phase
  // tick with bit_q == 0 means all eight bits have been clocked.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StSetup;
      StSetup: if (tick) state_d = StShift;
      StShift: if (tick && !sck_q && bit_q == 3'd0) state_d = StGap;
      StGap:   if (tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    half_d    = (state_q == StIdle || tick) ? '0 : half_q + CW'(1);
    bit_d     = bit_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          tx_sr_d = tx_data;
          mosi_d  = tx_data[7];
          bit_d   = 3'd0;
        end
      end
      StSetup: begin
        if (tick) sck_d = 1'b1;
      end
      StShift: begin
        if (tick) begin
          if (sck_q) begin
            sck_d   = 1'b0;
            rx_sr_d = {rx_sr_q[6:0], miso_s2_q};
            bit_d   = bit_q + 3'd1;
            if (bit_q != 3'd7) begin
              tx_sr_d = tx_sr_q << 1;
              mosi_d  = tx_sr_q[6];
            end
          end else if (bit_q == 3'd0) begin
            mosi_d    = 1'b0;
            done_d    = 1'b1;
            rx_data_d = rx_sr_q;
          end else begin
            sck_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    ss_d   = (state_d == StIdle) || (state_d == StGap);
    busy_d = (state_d != StIdle);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign SCK     = sck_q;
  assign MOSI    = mosi_q;
  assign SS      = ss_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV 4 and 2) checked cycle by cycle against
// a frame model derived from the frame timeline (all events at multiples of H after E0).
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sel;
  logic       loop;
  logic       miso_fix;
  logic [7:0] tx_data;

  logic       start4, busy4, done4, sck4, mosi4, ss4, miso4;
  logic       start2, busy2, done2, sck2, mosi2, ss2, miso2;
  logic [7:0] rx4, rx2;
  logic       m_busy, m_done, m_sck, m_mosi, m_ss;
  logic [7:0] m_rx;

  logic [7:0] last_rx [2];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  assign start4 = start & ~sel;
  assign start2 = start & sel;
  assign miso4  = loop ? mosi4 : miso_fix;
  assign miso2  = loop ? mosi2 : miso_fix;
  assign m_busy = sel ? busy2 : busy4;
  assign m_done = sel ? done2 : done4;
  assign m_sck  = sel ? sck2 : sck4;
  assign m_mosi = sel ? mosi2 : mosi4;
  assign m_ss   = sel ? ss2 : ss4;
  assign m_rx   = sel ? rx2 : rx4;

  spi_master #(.CLK_DIV(4)) u_dut4 (
    .clk_i(clk), .reset_i(rst), .start(start4), .tx_data(tx_data), .busy(busy4),
    .done(done4), .rx_data(rx4), .SCK(sck4), .MOSI(mosi4), .SS(ss4), .MISO(miso4)
  );

  spi_master #(.CLK_DIV(2)) u_dut2 (
    .clk_i(clk), .reset_i(rst), .start(start2), .tx_data(tx_data), .busy(busy2),
    .done(done2), .rx_data(rx2), .SCK(sck2), .MOSI(mosi2), .SS(ss2), .MISO(miso2)
  );

  // Raise start so that the next rising edge is E0; returns #1 after E0.
  task automatic start_frame(input logic [7:0] b);
    int n = 0;
    while (m_busy !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (m_busy !== 1'b0) begin
      errors++;
      $display("FAIL start_wait: busy=%b after %0d cycles, want 0", m_busy, n);
    end
    @(negedge clk);
    tx_data = b;
    start   = 1'b1;
    @(posedge clk); #1;
  endtask

  // Observes one frame from index 0 (#1 after E0) to index 18H and compares with the model.
  task automatic check_frame(input string name, input logic [7:0] b, input logic [7:0] exp_rx,
                             input logic [7:0] next_tx, input bit keep);
    int h, e_sck, e_ss, e_busy, e_done, e_rx, e_mosi, e_quiet, rises, ss_low, busy_hi;
    logic prev_sck, exp_sck;
    logic [7:0] prev;
    h = sel ? 2 : 4;
    prev = last_rx[sel];
    e_sck = 0; e_ss = 0; e_busy = 0; e_done = 0; e_rx = 0; e_mosi = 0; e_quiet = 0;
    rises = 0; ss_low = 0; busy_hi = 0;
    prev_sck = 1'b0;
    for (int m = 0; m <= 18 * h; m++) begin
      if (m > 0) begin
        @(posedge clk); #1;
      end
      if (m == 0 && !keep) start = 1'b0;
      if (m == 5) tx_data = next_tx;
      exp_sck = (m >= h) && (m < 17 * h) && (((m - h) / h) % 2 == 0);
      if (m_sck !== exp_sck) e_sck++;
      if (m_ss !== (m >= 17 * h)) e_ss++;
      if (m_busy !== (m < 18 * h)) e_busy++;
      if (m_done !== (m == 17 * h)) e_done++;
      if (m_rx !== ((m >= 17 * h) ? exp_rx : prev)) e_rx++;
      if (m == 0 && m_mosi !== b[7]) e_mosi++;
      if (m >= h && m < 17 * h && (m - h) % (2 * h) == 0 && m_mosi !== b[7 - (m - h) / (2 * h)])
        e_mosi++;
      if (m == 17 * h && m_mosi !== 1'b0) e_mosi++;
      if (m_ss === 1'b1 && m_sck !== 1'b0) e_quiet++;
      if (m_sck === 1'b1 && prev_sck === 1'b0) rises++;
      if (m_ss === 1'b0) ss_low++;
      if (m_busy === 1'b1) busy_hi++;
      prev_sck = m_sck;
    end
    checks += 10;
    if (e_sck != 0) begin errors++; $display("FAIL %s sck: %0d cycles off, want 0", name, e_sck); end
    if (e_ss != 0) begin errors++; $display("FAIL %s ss: %0d cycles off, want 0", name, e_ss); end
    if (e_busy != 0) begin errors++; $display("FAIL %s busy: %0d cycles off, want 0", name, e_busy); end
    if (e_done != 0) begin errors++; $display("FAIL %s done: %0d cycles off, want 0", name, e_done); end
    if (e_mosi != 0) begin errors++; $display("FAIL %s mosi: %0d bits off, want 0", name, e_mosi); end
    if (e_quiet != 0) begin errors++; $display("FAIL %s sck_while_ss: %0d, want 0", name, e_quiet); end
    if (rises != 8) begin errors++; $display("FAIL %s sck_rises: got %0d, want 8", name, rises); end
    if (ss_low != 17 * h) begin
      errors++; $display("FAIL %s ss_low_time: got %0d, want %0d", name, ss_low, 17 * h);
    end
    if (busy_hi != 18 * h) begin
      errors++; $display("FAIL %s busy_time: got %0d, want %0d", name, busy_hi, 18 * h);
    end
    if (e_rx != 0 || m_rx !== exp_rx) begin
      errors++;
      $display("FAIL %s rx_data: got %h (%0d cycles off), want %h", name, m_rx, e_rx, exp_rx);
    end
    last_rx[sel] = exp_rx;
  endtask

  task automatic test_reset();
    int e_ss = 0, e_sck = 0, e_mosi = 0, e_busy = 0, e_done = 0, e_rx = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ss4 !== 1'b1 || ss2 !== 1'b1) e_ss++;
      if (sck4 !== 1'b0 || sck2 !== 1'b0) e_sck++;
      if (mosi4 !== 1'b0 || mosi2 !== 1'b0) e_mosi++;
      if (busy4 !== 1'b0 || busy2 !== 1'b0) e_busy++;
      if (done4 !== 1'b0 || done2 !== 1'b0) e_done++;
      if (rx4 !== 8'h00 || rx2 !== 8'h00) e_rx++;
    end
    checks += 6;
    if (e_ss != 0) begin errors++; $display("FAIL reset_ss: %0d bad cycles, want 0", e_ss); end
    if (e_sck != 0) begin errors++; $display("FAIL reset_sck: %0d bad cycles, want 0", e_sck); end
    if (e_mosi != 0) begin errors++; $display("FAIL reset_mosi: %0d bad cycles, want 0", e_mosi); end
    if (e_busy != 0) begin errors++; $display("FAIL reset_busy: %0d bad cycles, want 0", e_busy); end
    if (e_done != 0) begin errors++; $display("FAIL reset_done: %0d bad cycles, want 0", e_done); end
    if (e_rx != 0) begin errors++; $display("FAIL reset_rx: %0d bad cycles, want 0", e_rx); end
    last_rx[0] = 8'h00;
    last_rx[1] = 8'h00;
  endtask

  task automatic test_loopback_a5();
    sel = 1'b0; loop = 1'b1;
    start_frame(8'hA5);
    check_frame("loop_a5", 8'hA5, 8'hA5, 8'($urandom), 1'b0);
  endtask

  task automatic test_tied_one_3c();
    sel = 1'b0; loop = 1'b0; miso_fix = 1'b1;
    repeat (3) @(posedge clk);
    start_frame(8'h3C);
    check_frame("tied1_3c", 8'h3C, 8'hFF, 8'($urandom), 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit lp, fv;
    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      lp = 1'($urandom_range(0, 1));
      fv = 1'($urandom_range(0, 1));
      loop = lp; miso_fix = fv;
      repeat (3) @(posedge clk);
      start_frame(b);
      check_frame("random", b, lp ? b : {8{fv}}, 8'($urandom), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0, b1, b2;
    sel = 1'b0; loop = 1'b1;
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
    start_frame(b0);
    check_frame("b2b_0", b0, b0, b1, 1'b1);
    @(posedge clk); #1;
    check_frame("b2b_1", b1, b1, b2, 1'b1);
    @(posedge clk); #1;
    check_frame("b2b_2", b2, b2, 8'($urandom), 1'b0);
  endtask

  task automatic test_reset_midframe();
    int e_done = 0;
    sel = 1'b0; loop = 1'b1;
    start_frame(8'hF0);
    start = 1'b0;
    repeat (29) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks += 3;
    if (ss4 !== 1'b1) begin errors++; $display("FAIL abort_ss: got %b, want 1", ss4); end
    if (sck4 !== 1'b0) begin errors++; $display("FAIL abort_sck: got %b, want 0", sck4); end
    if (rx4 !== 8'h00) begin errors++; $display("FAIL abort_rx: got %h, want 00", rx4); end
    repeat (3) begin
      @(posedge clk); #1;
      if (done4 !== 1'b0) e_done++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done4 !== 1'b0) e_done++;
    end
    checks++;
    if (e_done != 0) begin errors++; $display("FAIL abort_done: %0d pulses, want 0", e_done); end
    last_rx[0] = 8'h00;
    last_rx[1] = 8'h00;
    start_frame(8'h81);
    check_frame("after_abort_81", 8'h81, 8'h81, 8'($urandom), 1'b0);
  endtask

  task automatic test_clkdiv2();
    sel = 1'b1; loop = 1'b1;
    start_frame(8'h5A);
    check_frame("div2_5a", 8'h5A, 8'h5A, 8'($urandom), 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0; loop = 1'b1; miso_fix = 1'b0; tx_data = 8'h00;
    last_rx[0] = 8'h00;
    last_rx[1] = 8'h00;
    test_reset();
    test_loopback_a5();
    test_tied_one_3c();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    test_clkdiv2();
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCK half-period in clk_i cycles; legal range 2..255.
REQ-002 SHALL have port clk_i, input, 1 bit: system clock; all logic rising-edge on clk_i; one clock domain only.
REQ-003 SHALL have port reset_i, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: request a frame; sampled only when busy=0.
REQ-005 SHALL have port tx_data, input, 8 bits: byte to transmit; latched at frame acceptance.
REQ-006 SHALL have port busy, output, 1 bit: frame in progress, including the inter-frame gap.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.
REQ-008 SHALL have port rx_data, output, 8 bits: last byte received on MISO.
REQ-009 SHALL have port SCK, output, 1 bit: SPI clock, mode 0 (idle low).
REQ-010 SHALL have port MOSI, output, 1 bit: serial data out, MSB first.
REQ-011 SHALL have port SS, output, 1 bit: slave select, active low.
REQ-012 SHALL have port MISO, input, 1 bit: serial data in, asynchronous to clk_i.

Function
REQ-013 SHALL implement FSM IDLE -> SETUP -> SHIFT -> GAP -> IDLE.
- H = CLK_DIV; E0 = the clk_i edge accepting start.
- All outputs SHALL be registered.
REQ-014 IDLE: SS=1, SCK=0, busy=0.
- start=1 at E0 latches tx_data into the TX shift register and enters SETUP.
- From E0: SS=0, busy=1, MOSI=tx_data[7].
REQ-015 SETUP: SS=0, SCK=0 for H cycles; exits to SHIFT at E0+H with SCK driven high.
REQ-016 SHIFT: exactly 8 bit periods of 2H cycles each.
- Bit k (k=0..7): SCK high at E0+H+2kH; SCK low at E0+2H+2kH.
REQ-017 MISO SHALL pass through a 2-flop synchronizer.
- Synchronized value shifts into the LSB of the RX shift register at each edge where SCK is driven low (8 samples, MSB first).
REQ-018 MOSI SHALL advance to the next TX bit on the same edge SCK is driven low, for bits 0..6 only.
- MOSI holds bit 0 through the final low phase.
REQ-019 A 3-bit bit counter and a half-period counter (width ceil(log2(CLK_DIV))+1) SHALL sequence SHIFT.
- Counters wrap/reload; no other width growth.
REQ-020 After the 8th low phase (H cycles), at E0+17H:
- SS=1, MOSI=0, rx_data <= RX shift register, done=1 for exactly one cycle, state=GAP.
REQ-021 GAP: SS=1, SCK=0 for H cycles.
- At E0+18H: busy=0, state=IDLE.
- Minimum SS-high time between frames SHALL be H cycles.
REQ-022 start while busy=1 SHALL be ignored; tx_data changes after E0 SHALL NOT affect the frame in flight.
REQ-023 start held high continuously SHALL produce back-to-back frames: next E0 on the first IDLE cycle.
REQ-024 Each frame SHALL produce exactly 8 SCK rising edges; no SCK activity while SS=1.
REQ-025 rx_data SHALL change only at frame completion; it holds its value otherwise.

Reset
REQ-026 reset_i=1 SHALL asynchronously force:
- state=IDLE, SS=1, SCK=0, MOSI=0, busy=0, done=0, rx_data=8'h00;
- all counters, shift registers and synchronizer flops to 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no done pulse.
- The first start after reset release SHALL run a complete, correct frame.

Verification
REQ-028 Reset with no start -> SS=1, SCK=0, MOSI=0, busy=0, done=0, rx_data=8'h00 for 100 cycles.
REQ-029 CLK_DIV=4, MISO looped to MOSI, start with tx_data=8'hA5 ->
- SCK first rise at E0+4, last fall at E0+64;
- SS high at E0+68; done pulse in cycle E0+68; rx_data=8'hA5; busy low at E0+72.
REQ-030 tx_data=8'h3C, MISO tied 1 ->
- MOSI at the 8 SCK rising edges reads 0,0,1,1,1,1,0,0;
- rx_data=8'hFF; exactly 8 SCK rises.
REQ-031 start held high for 3 frames, tx_data changed mid-frame ->
- 3 done pulses; SS high at least 4 cycles between frames;
- each frame transmits the byte latched at its own E0.
REQ-032 Reset pulse during bit 3 of a frame (tx 8'hF0) ->
- immediate SS=1, SCK=0, no done pulse;
- next frame with tx 8'h81 and loopback gives rx_data=8'h81.
REQ-033 CLK_DIV=2 with the 8'h5A loopback -> rx_data=8'h5A, SS-low time 34 cycles, busy time 36 cycles.
